// File: rtl/ball_collision_arbiter.sv
// Collects per-source ball collision requests over a frame and issues one bounce command per frame.
// Optional round-robin arbitration: define COLLISION_ARB_ROUND_ROBIN_EN.
module ball_collision_arbiter #(
    parameter int unsigned NUM_SRC         = 6,
    parameter int unsigned COOLDOWN_FRAMES = 3,
    parameter int unsigned CNT_W           = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               pause,
    input  logic               reset_level,
    input  logic [NUM_SRC-1:0] req,
    input  logic [3:0]         hitEdgeCode,
    output logic               grantValid,
    output logic [2:0]         grantSrc,
    output logic [3:0]         grantEdge,
    output logic               flipX,
    output logic               flipY,
    output logic               busy
);

    localparam int unsigned SRC_W = 3;
    localparam logic [NUM_SRC-1:0] SRC_ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t             state, nextState;
    logic [NUM_SRC-1:0] pending, nextPending;
    logic [3:0]         edgeAcc, nextEdgeAcc;
    logic [CNT_W-1:0]   cnt, nextCnt;
    logic               nextGrantValid, nextFlipX, nextFlipY, nextBusy;
    logic [2:0]         nextGrantSrc;
    logic [3:0]         nextGrantEdge;

    logic [SRC_W-1:0]   winner;
    logic               found;
    int unsigned        idx;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] capPending;
    logic [3:0]         capEdge;

`ifdef COLLISION_ARB_ROUND_ROBIN_EN
    logic [SRC_W-1:0]   rrPtr, nextRrPtr;
`endif

    // Winner search: lowest set index, starting at rrPtr when round-robin is enabled
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
            idx = 32'(rrPtr) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
`else
            idx = i;
`endif
            if (!found && pending[SRC_W'(idx)]) begin
                found  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end

    // Next-state, capture and output decode
    always_comb begin
        nextState      = state;
        nextPending    = pending;
        nextEdgeAcc    = edgeAcc;
        nextCnt        = cnt;
        nextGrantValid = 1'b0;
        nextFlipX      = 1'b0;
        nextFlipY      = 1'b0;
        nextGrantSrc   = grantSrc;
        nextGrantEdge  = grantEdge;
        nextBusy       = busy;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
        nextRrPtr      = rrPtr;
`endif
        mask       = (state == COLLECT) ? '0 : (SRC_ONE << grantSrc);
        capPending = req & ~mask;
        capEdge    = (req[4] | req[5]) ? hitEdgeCode : 4'b0000;

        if (reset_level) begin
            nextState     = COLLECT;
            nextPending   = '0;
            nextEdgeAcc   = '0;
            nextCnt       = '0;
            nextGrantSrc  = '0;
            nextGrantEdge = '0;
            nextBusy      = 1'b0;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
            nextRrPtr     = '0;
`endif
        end else if (!pause) begin
            nextPending = pending | capPending;
            nextEdgeAcc = edgeAcc | capEdge;
            case (state)
                COLLECT: begin
                    if (startOfFrame && (pending != '0)) begin
                        nextState      = GRANT;
                        nextGrantValid = 1'b1;
                        nextGrantSrc   = winner;
                        nextGrantEdge  = edgeAcc;
                        nextFlipY      = (winner == 3'd0) || (winner == 3'd3) ||
                                         ((winner >= 3'd4) && (edgeAcc[2] || edgeAcc[0]));
                        nextFlipX      = (winner == 3'd1) || (winner == 3'd2) ||
                                         ((winner >= 3'd4) && (edgeAcc[3] || edgeAcc[1]));
                        nextCnt        = CNT_W'(COOLDOWN_FRAMES);
                        // Snapshot taken; this clk's requests open the next frame
                        nextPending    = capPending;
                        nextEdgeAcc    = capEdge;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
                        nextRrPtr      = (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + SRC_W'(1);
`endif
                    end
                end
                GRANT: begin
                    nextState = (COOLDOWN_FRAMES > 0) ? COOLDOWN : COLLECT;
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt <= CNT_W'(1)) begin
                            nextCnt   = '0;
                            nextState = COLLECT;
                        end else begin
                            nextCnt = cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    nextState = COLLECT;
                end
            endcase
            nextBusy = (nextState == COOLDOWN);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= COLLECT;
            pending    <= '0;
            edgeAcc    <= '0;
            cnt        <= '0;
            grantValid <= 1'b0;
            grantSrc   <= '0;
            grantEdge  <= '0;
            flipX      <= 1'b0;
            flipY      <= 1'b0;
            busy       <= 1'b0;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
            rrPtr      <= '0;
`endif
        end else begin
            state      <= nextState;
            pending    <= nextPending;
            edgeAcc    <= nextEdgeAcc;
            cnt        <= nextCnt;
            grantValid <= nextGrantValid;
            grantSrc   <= nextGrantSrc;
            grantEdge  <= nextGrantEdge;
            flipX      <= nextFlipX;
            flipY      <= nextFlipY;
            busy       <= nextBusy;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
            rrPtr      <= nextRrPtr;
`endif
        end
    end

endmodule
